match_req_dispatch: RTL and testbench
=====================================

// Module: match_req_dispatch
// PURPOSE
//  Upstream neighbour of the match response collector. Accepts one lazy-match request group
//  (L lanes, per-lane strobe and history address), issues the strobed lanes as tagged requests
//  over C match-PE request channels, and announces each group (valid + strobe) to the collector.
//  Holds off the next group until the collector reports the current group's response consumed.
// PARAMETERS
//  L         `LAZY_LEN (4)          lanes per request group
//  C         `NUM_MATCH_REQ_CH (2)  match request channels
//  TAG_BITS  `LAZY_LEN_LOG2 (2)     tag width = lane index width
//  AW        `HASH_ADDR_WIDTH (16)  history address width per lane
// PORTS
//  clk              in   1         clock
//  rst_n            in   1         synchronous active-low reset
//  in_valid         in   1         request group valid
//  in_ready         out  1         group accepted when in_valid & in_ready
//  in_strb          in   L         lane i carries a request when set
//  in_addr          in   L*AW      lane i address at [i*AW +: AW]
//  req_valid        out  C         per-channel request valid
//  req_ready        in   C         per-channel request ready
//  req_tag          out  C*TAG_BITS  lane index of request on channel c
//  req_addr         out  C*AW      address of request on channel c
//  sync_group_valid out  1         one-cycle pulse announcing a new group to the collector
//  sync_group_strb  out  L         strobe of announced group (valid with pulse)
//  group_done       in   1         collector's resp_group_valid & resp_group_ready
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, addr regs=0, in_ready=1, req_valid=0, sync_group_valid=0,
//    sync_group_strb=0. Reset mid-group discards pending lanes; no further requests issued.
//  - FSM IDLE/ISSUE/WAIT. in_ready = (state==IDLE), combinational from state only.
//  - IDLE: on in_valid&in_ready at edge T: pending<=in_strb, addr regs<=in_addr,
//    sync_group_valid<=1, sync_group_strb<=in_strb (both registered, high during cycle T+1 only);
//    state<=ISSUE if in_strb!=0 else WAIT.
//  - ISSUE: lane i is owned by channel (i mod C). req_valid[c]=1 iff some pending lane owned by c;
//    it presents the lowest such lane: req_tag=i, req_addr=addr[i]. Outputs driven from regs,
//    so first requests are visible in cycle T+1 together with the announce pulse.
//    On req_valid[c]&req_ready[c], clear pending[i]; channels complete independently, several
//    per cycle. req_tag/req_addr stable while req_valid&~req_ready. When all pending bits clear
//    at an edge, state<=WAIT. req_valid=0 outside ISSUE; req_tag/req_addr=0 when req_valid=0.
//  - WAIT: on group_done, state<=IDLE (in_ready=1 next cycle). Empty group (strb=0): collector
//    completes it by itself, WAIT exits on its group_done.
//  - group_done in IDLE or ISSUE is ignored (protocol violation; bench asserts it never occurs).
//  - Ordering: announce lands at collector edge T+1; match PEs have >=1 cycle latency, so no
//    response for the group reaches the collector before its done vector is reloaded.
//  - Throughput: ceil(max lanes per channel) cycles issue with no backpressure; at most one
//    group in flight.
//  - Width: tag = i[TAG_BITS-1:0]; L must be <= 2**TAG_BITS and C <= L.
// TESTING (L=4, C=2, AW=16)
//  1 strb=4'b1111, addr={40,30,20,10}, req_ready=2'b11 -> cycle T+1 pulse strb=1111, ch0 tag0/10,
//    ch1 tag1/20; T+2 ch0 tag2/30, ch1 tag3/40; T+3 req_valid=0, WAIT; in_ready low until group_done.
//  2 strb=4'b0101, req_ready=2'b11 -> only ch0 issues: tag0 then tag2; req_valid[1] never set.
//  3 strb=4'b1111, req_ready[1]=0 for 5 cycles -> ch1 holds tag1/addr stable; ch0 finishes
//    tags 0,2; WAIT entered only after ch1 issues tags 1,3.
//  4 strb=0 -> pulse with strb=0000, no req_valid, WAIT; group_done -> in_ready=1 next cycle.
//  5 back-to-back in_valid high -> second group accepted only the cycle after group_done;
//    group_done injected during ISSUE has no effect.
//  6 rst_n low mid-ISSUE with 2 lanes pending -> next cycle req_valid=0, in_ready=1, no pulse.

Source files
------------

// File: rtl/match_req_dispatch.sv
// Lazy-match request dispatcher: takes one strobed lane group, issues each lane as a tagged request
// on its owning channel (lane mod C), announces the group to the collector and waits for its completion.
module match_req_dispatch #(
  parameter int L        = 4,
  parameter int C        = 2,
  parameter int TAG_BITS = 2,
  parameter int AW       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [L-1:0]          in_strb,
  input  logic [L*AW-1:0]       in_addr,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*AW-1:0]       req_addr,
  output logic                  sync_group_valid,
  output logic [L-1:0]          sync_group_strb,
  input  logic                  group_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                       state_reg, state_next;
  logic [L-1:0]                 pending_reg, pending_next;
  logic [L*AW-1:0]              addr_reg;
  logic                         sync_valid_reg;
  logic [L-1:0]                 sync_strb_reg;
  logic [C-1:0]                 fire;
  logic [L-1:0]                 lane_clr;
  logic [C-1:0][TAG_BITS-1:0]   ch_lane;

  // Lanes owned by channel c: every lane index congruent to c modulo C.
  function automatic logic [L-1:0] owner_mask(input int c);
    logic [L-1:0] m;
    m = '0;
    for (int i = 0; i < L; i++) m[i] = ((i % C) == c);
    return m;
  endfunction

  function automatic logic [TAG_BITS-1:0] lowest_lane(input logic [L-1:0] v);
    logic [TAG_BITS-1:0] r;
    r = '0;
    for (int i = L - 1; i >= 0; i--) if (v[i]) r = TAG_BITS'(i);
    return r;
  endfunction

  assign in_ready         = (state_reg == IDLE);
  assign sync_group_valid = sync_valid_reg;
  assign sync_group_strb  = sync_strb_reg;
  assign fire             = req_valid & req_ready;

  for (genvar gi = 0; gi < C; gi++) begin : g_ch
    logic [L-1:0]          own;
    logic [TAG_BITS-1:0]   lane;
    assign own                             = pending_reg & owner_mask(gi);
    assign lane                            = lowest_lane(own);
    assign ch_lane[gi]                     = lane;
    assign req_valid[gi]                   = (state_reg == ISSUE) && (own != '0);
    assign req_tag[gi*TAG_BITS +: TAG_BITS] = req_valid[gi] ? lane : '0;
    assign req_addr[gi*AW +: AW]           = req_valid[gi] ? addr_reg[int'(lane)*AW +: AW] : '0;
  end

  // A lane retires only when its owning channel is presenting exactly that lane and handshakes.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    assign lane_clr[gi] = fire[gi % C] && (ch_lane[gi % C] == TAG_BITS'(gi));
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          pending_next = in_strb;
          state_next   = (in_strb != '0) ? ISSUE : WAIT;
        end
      end
      ISSUE: begin
        pending_next = pending_reg & ~lane_clr;
        if (pending_next == '0) state_next = WAIT;
      end
      WAIT: begin
        if (group_done) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      addr_reg       <= '0;
      sync_valid_reg <= 1'b0;
      sync_strb_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      sync_valid_reg <= 1'b0;
      sync_strb_reg  <= '0;
      if (state_reg == IDLE && in_valid) begin
        addr_reg       <= in_addr;
        sync_valid_reg <= 1'b1;
        sync_strb_reg  <= in_strb;
      end
    end
  end

endmodule

// File: tb/tb_match_req_dispatch.sv
// Scoreboard bench: the driver pushes expected announces and per-channel request streams on accept;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_match_req_dispatch;
  localparam int L = 4, C = 2, TB = 2, AW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [L-1:0]     in_strb;
  logic [L*AW-1:0]  in_addr;
  logic [C-1:0]     req_valid;
  logic [C-1:0]     req_ready;
  logic [C*TB-1:0]  req_tag;
  logic [C*AW-1:0]  req_addr;
  logic             sync_group_valid;
  logic [L-1:0]     sync_group_strb;
  logic             group_done;

  typedef struct { int due; logic [L-1:0] strb; } ann_t;
  typedef struct { logic [TB-1:0] tag; logic [AW-1:0] addr; } req_t;

  ann_t ann_q[$];
  req_t exp_q[C][$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   ready_force = 1'b1;
  logic [C-1:0] ready_val = '0;

  match_req_dispatch #(.L(L), .C(C), .TAG_BITS(TB), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_strb(in_strb), .in_addr(in_addr), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_addr(req_addr), .sync_group_valid(sync_group_valid),
    .sync_group_strb(sync_group_strb), .group_done(group_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    req_ready = ready_force ? ready_val : C'($urandom);
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented announce / request against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ann_q.size() != 0 && ann_q[0].due == cyc) begin
        chk_eq("announce_valid", 32'(sync_group_valid), 32'd1);
        chk_eq("announce_strb", 32'(sync_group_strb), 32'(ann_q[0].strb));
        $display("announce strb=%b at cycle %0d", sync_group_strb, cyc);
        void'(ann_q.pop_front());
      end else begin
        chk_eq("no_announce", 32'(sync_group_valid), 32'd0);
      end
      for (int c = 0; c < C; c++) begin
        if (exp_q[c].size() == 0) begin
          chk_eq("req_valid_unexpected", 32'(req_valid[c]), 32'd0);
        end else if (req_valid[c]) begin
          chk_eq("req_tag", 32'(req_tag[c*TB +: TB]), 32'(exp_q[c][0].tag));
          chk_eq("req_addr", 32'(req_addr[c*AW +: AW]), 32'(exp_q[c][0].addr));
          if (req_ready[c]) begin
            $display("req ch%0d tag=%0d addr=%0h at cycle %0d", c, req_tag[c*TB +: TB],
                     req_addr[c*AW +: AW], cyc);
            void'(exp_q[c].pop_front());
          end
        end
        if (!req_valid[c]) begin
          chk_eq("idle_tag_zero", 32'(req_tag[c*TB +: TB]), 32'd0);
          chk_eq("idle_addr_zero", 32'(req_addr[c*AW +: AW]), 32'd0);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge (cycle T+1).
  task automatic send_group(input logic [L-1:0] s, input logic [L*AW-1:0] a);
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_strb  = s;
    in_addr  = a;
    while (!acc && n < 300) begin
      @(negedge clk);
      n++;
      if (in_ready) begin
        acc = 1'b1;
        ann_q.push_back('{due: cyc + 1, strb: s});
        for (int i = 0; i < L; i++)
          if (s[i]) exp_q[i % C].push_back('{tag: TB'(i), addr: a[i*AW +: AW]});
      end
    end
    if (!acc) chk_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_strb  = L'($urandom);
    in_addr  = {$urandom, $urandom};
  endtask

  task automatic finish_group();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + ann_q.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk_eq("drain_timeout", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq("wait_holds_off", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    group_done = 1'b1;
    @(negedge clk);
    chk_eq("done_cycle_not_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    group_done = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_done", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_strb = '0; in_addr = '0; group_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("reset_in_ready", 32'(in_ready), 32'd1);
    chk_eq("reset_req_valid", 32'(req_valid), 32'd0);
    chk_eq("reset_sync_valid", 32'(sync_group_valid), 32'd0);
    chk_eq("reset_sync_strb", 32'(sync_group_strb), 32'd0);
    @(posedge clk); #1;

    // Full group, no backpressure: two issue cycles then idle.
    ready_force = 1'b1; ready_val = 2'b11;
    send_group(4'b1111, {16'd40, 16'd30, 16'd20, 16'd10});
    @(negedge clk); chk_eq("t1_issue1", 32'(req_valid), 32'h3);
    @(negedge clk); chk_eq("t1_issue2", 32'(req_valid), 32'h3);
    @(negedge clk); chk_eq("t1_issue_end", 32'(req_valid), 32'h0);
    chk_eq("t1_not_ready", 32'(in_ready), 32'd0);
    finish_group();

    // Only channel 0 lanes.
    send_group(4'b0101, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    @(negedge clk); chk_eq("t2_ch0_only_a", 32'(req_valid), 32'h1);
    @(negedge clk); chk_eq("t2_ch0_only_b", 32'(req_valid), 32'h1);
    finish_group();

    // Channel 1 stalled for 5 cycles.
    ready_val = 2'b01;
    send_group(4'b1111, {16'hd004, 16'hc003, 16'hb002, 16'ha001});
    repeat (5) begin
      @(negedge clk);
      chk_eq("t3_ch1_hold_valid", 32'(req_valid[1]), 32'd1);
      chk_eq("t3_ch1_hold_tag", 32'(req_tag[3:2]), 32'd1);
    end
    @(posedge clk); #1;
    ready_val = 2'b11;
    finish_group();

    // Empty group.
    send_group(4'b0000, {4{16'hbeef}});
    @(negedge clk); chk_eq("t4_no_req", 32'(req_valid), 32'h0);
    finish_group();

    // Back-to-back groups; group_done during ISSUE must be ignored.
    ready_val = 2'b00;
    send_group(4'b1111, {16'h0a04, 16'h0a03, 16'h0a02, 16'h0a01});
    fork
      send_group(4'b0110, {16'h0b04, 16'h0b03, 16'h0b02, 16'h0b01});
      begin
        @(posedge clk); #1 group_done = 1'b1;
        @(posedge clk); #1 group_done = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk_eq("t5_done_ignored", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        ready_val = 2'b11;
        finish_group();
      end
    join
    finish_group();

    // Reset with two lanes pending.
    ready_val = 2'b00;
    send_group(4'b0011, {16'h0, 16'h0, 16'h5502, 16'h5501});
    @(negedge clk); chk_eq("t6_pre_reset", 32'(req_valid), 32'h3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q[0].delete(); exp_q[1].delete(); ann_q.delete();
    @(negedge clk);
    chk_eq("t6_req_cleared", 32'(req_valid), 32'h0);
    chk_eq("t6_in_ready", 32'(in_ready), 32'd1);
    chk_eq("t6_no_pulse", 32'(sync_group_valid), 32'd0);
    @(negedge clk);
    chk_eq("t6_still_quiet", 32'(req_valid), 32'h0);
    @(posedge clk); #1;

    // Randomized groups with random backpressure.
    ready_force = 1'b0;
    for (int g = 0; g < 25; g++) begin
      send_group(L'($urandom_range(0, 15)), {$urandom, $urandom});
      finish_group();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
